// File: rtl/ts_pkg.sv
// Shared constants and types for the per-neuron timestamp scanner.
// Module-level widths come from the scanner's parameters; these are the defaults.
package ts_pkg;

  localparam int unsigned SCAL_ADDR_LEN_DEF = 8;
  localparam int unsigned TEMP_ADDR_LEN_DEF = 8;
  localparam int unsigned T_FIX_WID         = SCAL_ADDR_LEN_DEF + TEMP_ADDR_LEN_DEF;
  localparam logic [T_FIX_WID-1:0] TS_MAX   = {T_FIX_WID{1'b1}};

  // Exponential-stage latency; the drain phase covers it plus the read and present stages.
  localparam int unsigned EFA_LAT   = 4;
  localparam int unsigned DRAIN_CYC = EFA_LAT + 2;

  typedef enum logic [1:0] {
    StInit,
    StIdle,
    StScan,
    StDrain
  } ts_state_e;

endpackage

// File: rtl/ts_ram.sv
// Simple dual-port timestamp store: one write port, one read port with a
// single registered read stage. No reset on the array so it maps to distributed RAM.
module ts_ram #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8,
  parameter int unsigned DW    = 16
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ts_timer_scan.sv
// Per-neuron elapsed-time scanner: on each tick, reads every neuron's timestamp,
// presents it (0 if the neuron spiked since the last read) and writes back +1.
module ts_timer_scan
  import ts_pkg::*;
#(
  parameter int unsigned NEURON_NUM    = 256,
  parameter int unsigned SCAL_ADDR_LEN = 8,
  parameter int unsigned TEMP_ADDR_LEN = 8,
  localparam int unsigned NEUR_ADDR_LEN = $clog2(NEURON_NUM),
  localparam int unsigned TFW           = SCAL_ADDR_LEN + TEMP_ADDR_LEN
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_tick,
  input  logic                     i_spike_in,
  input  logic [NEUR_ADDR_LEN-1:0] i_spike_addr,
  output logic                     o_re,
  output logic [TFW-1:0]           o_t_fix_reg,
  output logic                     o_efa_vld,
  output logic [NEUR_ADDR_LEN-1:0] o_efa_addr,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_tick_ovr
);

  localparam logic [NEUR_ADDR_LEN-1:0] LastAddr  = NEUR_ADDR_LEN'(NEURON_NUM - 1);
  localparam logic [TFW-1:0]           TsMaxL    = {TFW{1'b1}};
  localparam logic [2:0]               DrainLast = 3'(DRAIN_CYC - 1);

  ts_state_e                r_state, w_state_nxt;
  logic [NEUR_ADDR_LEN-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]               r_drain, w_drain_nxt;
  logic [NEURON_NUM-1:0]    r_pend;
  logic                     r_re;
  logic                     r_pend_hit;
  logic [NEUR_ADDR_LEN-1:0] r_rd_addr;
  logic                     r_tick_ovr;
  logic [EFA_LAT-1:0]       r_efa_vld;
  logic [NEUR_ADDR_LEN-1:0] r_efa_addr [EFA_LAT];

  logic                     w_issue;
  logic [TFW-1:0]           w_rdata;
  logic [TFW-1:0]           w_tfix;
  logic [TFW-1:0]           w_wb;
  logic                     w_we;
  logic [NEUR_ADDR_LEN-1:0] w_waddr;
  logic [TFW-1:0]           w_wdata;

  assign w_issue = (r_state == StScan);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_drain_nxt = r_drain;
    unique case (r_state)
      StInit: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == LastAddr) begin
          w_state_nxt = StIdle;
          w_cnt_nxt   = '0;
        end
      end
      StIdle: begin
        if (i_tick) begin
          w_state_nxt = StScan;
          w_cnt_nxt   = '0;
        end
      end
      StScan: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == LastAddr) begin
          w_state_nxt = StDrain;
          w_cnt_nxt   = '0;
          w_drain_nxt = '0;
        end
      end
      StDrain: begin
        w_drain_nxt = r_drain + 1'b1;
        if (r_drain == DrainLast) begin
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StInit;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= StInit;
      r_cnt      <= '0;
      r_drain    <= '0;
      r_re       <= 1'b0;
      r_pend_hit <= 1'b0;
      r_rd_addr  <= '0;
      r_tick_ovr <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_drain    <= w_drain_nxt;
      r_re       <= w_issue;
      r_pend_hit <= r_pend[r_cnt];
      r_rd_addr  <= r_cnt;
      if (i_tick && (r_state != StIdle)) begin
        r_tick_ovr <= 1'b1;
      end
    end
  end

  // A spike landing on the neuron being read this cycle must survive to the next step,
  // so the set is ordered after the clear.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pend <= '0;
    end else begin
      if (w_issue) begin
        r_pend[r_cnt] <= 1'b0;
      end
      if (i_spike_in && (r_state != StInit)) begin
        r_pend[i_spike_addr] <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_efa_vld <= '0;
      for (int i = 0; i < EFA_LAT; i++) begin
        r_efa_addr[i] <= '0;
      end
    end else begin
      r_efa_vld     <= {r_efa_vld[EFA_LAT-2:0], r_re};
      r_efa_addr[0] <= r_rd_addr;
      for (int i = 1; i < EFA_LAT; i++) begin
        r_efa_addr[i] <= r_efa_addr[i-1];
      end
    end
  end

  assign w_tfix  = r_re ? (r_pend_hit ? '0 : w_rdata) : '0;
  assign w_wb    = (w_tfix == TsMaxL) ? TsMaxL : w_tfix + 1'b1;
  assign w_we    = !i_reset && ((r_state == StInit) || r_re);
  assign w_waddr = (r_state == StInit) ? r_cnt : r_rd_addr;
  assign w_wdata = (r_state == StInit) ? TsMaxL : w_wb;

  ts_ram #(
    .DEPTH (NEURON_NUM),
    .AW    (NEUR_ADDR_LEN),
    .DW    (TFW)
  ) u_ts_ram (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_issue),
    .i_raddr (r_cnt),
    .o_rdata (w_rdata)
  );

  assign o_re        = r_re;
  assign o_t_fix_reg = w_tfix;
  assign o_efa_vld   = r_efa_vld[EFA_LAT-1];
  assign o_efa_addr  = r_efa_addr[EFA_LAT-1];
  assign o_busy      = (r_state != StIdle);
  assign o_done      = (r_state == StDrain) && (r_drain == DrainLast);
  assign o_tick_ovr  = r_tick_ovr;

endmodule

// File: tb/tb_ts_timer_scan.sv
// Directed bench for ts_timer_scan: init, scan timing, spike accumulation,
// read/spike race, tick overrun and mid-scan reset.
module tb_ts_timer_scan;

  localparam int N = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick = 1'b0;
  logic        spike_in = 1'b0;
  logic [7:0]  spike_addr = '0;
  logic        o_re;
  logic [15:0] o_t_fix_reg;
  logic        o_efa_vld;
  logic [7:0]  o_efa_addr;
  logic        o_busy;
  logic        o_done;
  logic        o_tick_ovr;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] cap [N];
  int re_n, first_re, first_efa, last_efa, efa_n, efa_bad, done_k, idle_nz;

  ts_timer_scan dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_tick       (tick),
    .i_spike_in   (spike_in),
    .i_spike_addr (spike_addr),
    .o_re         (o_re),
    .o_t_fix_reg  (o_t_fix_reg),
    .o_efa_vld    (o_efa_vld),
    .o_efa_addr   (o_efa_addr),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_tick_ovr   (o_tick_ovr)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish before 2ms");
    $fatal(1);
  end

  // Tick from IDLE and record everything seen until done (k = cycles after the tick cycle).
  task automatic run_scan(input int sp_off, input logic [7:0] sp_addr, input int tk_off);
    re_n = 0; first_re = -1; first_efa = -1; last_efa = -1;
    efa_n = 0; efa_bad = 0; done_k = -1; idle_nz = 0;
    for (int i = 0; i < N; i++) cap[i] = '0;
    @(posedge clk); #1;
    tick = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk); #1;
      tick       = (k == tk_off);
      spike_in   = (k == sp_off);
      spike_addr = sp_addr;
      if (o_re) begin
        if (re_n < N) cap[re_n] = o_t_fix_reg;
        if (re_n == 0) first_re = k;
        re_n++;
      end else if (o_t_fix_reg !== 16'd0) begin
        idle_nz++;
      end
      if (o_efa_vld) begin
        if (efa_n == 0) first_efa = k;
        if (o_efa_addr !== 8'(efa_n)) efa_bad++;
        last_efa = k;
        efa_n++;
      end
      if (o_done) begin
        done_k = k;
        break;
      end
    end
    tick = 1'b0;
    spike_in = 1'b0;
  endtask

  task automatic test_reset();
    int fall;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (o_re !== 1'b0) begin n_fail++; $display("FAIL rst_re: got %b expected 0", o_re); end
    n_tests++; if (o_t_fix_reg !== 16'd0) begin n_fail++; $display("FAIL rst_tfix: got %0d expected 0", o_t_fix_reg); end
    n_tests++; if (o_efa_vld !== 1'b0) begin n_fail++; $display("FAIL rst_efa_vld: got %b expected 0", o_efa_vld); end
    n_tests++; if (o_efa_addr !== 8'd0) begin n_fail++; $display("FAIL rst_efa_addr: got %0d expected 0", o_efa_addr); end
    n_tests++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b expected 0", o_done); end
    n_tests++; if (o_tick_ovr !== 1'b0) begin n_fail++; $display("FAIL rst_tick_ovr: got %b expected 0", o_tick_ovr); end
    n_tests++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy: got %b expected 1", o_busy); end
    reset = 1'b0;
    fall = -1;
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk); #1;
      spike_in   = (c == 3);   // spike during INIT must be ignored
      spike_addr = 8'd7;
      if (!o_busy) begin fall = c; break; end
    end
    spike_in = 1'b0;
    n_tests++; if (fall != 256) begin n_fail++; $display("FAIL init_len: got %0d expected 256", fall); end
  endtask

  task automatic test_all_max();
    int bad;
    run_scan(0, 8'd0, 0);
    bad = 0;
    for (int i = 0; i < N; i++) if (cap[i] !== 16'hFFFF) bad++;
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL all_max: got %0d non-65535 values expected 0", bad); end
    n_tests++; if (re_n != 256) begin n_fail++; $display("FAIL re_count: got %0d expected 256", re_n); end
    n_tests++; if (first_re != 2) begin n_fail++; $display("FAIL first_re: got t+%0d expected t+2", first_re); end
    n_tests++; if (first_efa != 6) begin n_fail++; $display("FAIL first_efa: got t+%0d expected t+6", first_efa); end
    n_tests++; if (last_efa != 261) begin n_fail++; $display("FAIL last_efa: got t+%0d expected t+261", last_efa); end
    n_tests++; if (efa_n != 256) begin n_fail++; $display("FAIL efa_count: got %0d expected 256", efa_n); end
    n_tests++; if (efa_bad != 0) begin n_fail++; $display("FAIL efa_addr_seq: got %0d misordered expected 0", efa_bad); end
    n_tests++; if (done_k != 262) begin n_fail++; $display("FAIL done_time: got t+%0d expected t+262", done_k); end
    n_tests++; if (idle_nz != 0) begin n_fail++; $display("FAIL tfix_when_idle: got %0d nonzero expected 0", idle_nz); end
    n_tests++; if (o_tick_ovr !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b expected 0", o_tick_ovr); end
    @(posedge clk); #1;
    n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL busy_after_done: got %b expected 0", o_busy); end
    n_tests++; if (o_done !== 1'b0) begin n_fail++; $display("FAIL done_pulse: got %b expected 0", o_done); end
  endtask

  task automatic test_spike_accum();
    int bad;
    @(posedge clk); #1;
    spike_in = 1'b1; spike_addr = 8'd5;
    @(posedge clk); #1;
    spike_in = 1'b0;
    for (int s = 0; s < 3; s++) begin
      run_scan(0, 8'd0, 0);
      n_tests++;
      if (cap[5] !== 16'(s)) begin n_fail++; $display("FAIL accum_n5_step%0d: got %0d expected %0d", s, cap[5], s); end
      bad = 0;
      for (int i = 0; i < N; i++) if (i != 5 && cap[i] !== 16'hFFFF) bad++;
      n_tests++;
      if (bad != 0) begin n_fail++; $display("FAIL accum_others_step%0d: got %0d off values expected 0", s, bad); end
    end
  endtask

  task automatic test_spike_race();
    // Read of neuron 10 issues at t+11.
    run_scan(11, 8'd10, 0);
    n_tests++; if (cap[10] !== 16'hFFFF) begin n_fail++; $display("FAIL race_same_step: got %0d expected 65535", cap[10]); end
    n_tests++; if (cap[5] !== 16'd3) begin n_fail++; $display("FAIL race_n5: got %0d expected 3", cap[5]); end
    run_scan(0, 8'd0, 0);
    n_tests++; if (cap[10] !== 16'd0) begin n_fail++; $display("FAIL race_next_step: got %0d expected 0", cap[10]); end
    n_tests++; if (cap[5] !== 16'd4) begin n_fail++; $display("FAIL race_n5_next: got %0d expected 4", cap[5]); end
  endtask

  task automatic test_tick_ovr();
    run_scan(0, 8'd0, 50);
    n_tests++; if (done_k != 262) begin n_fail++; $display("FAIL ovr_done_time: got t+%0d expected t+262", done_k); end
    n_tests++; if (re_n != 256) begin n_fail++; $display("FAIL ovr_re_count: got %0d expected 256", re_n); end
    n_tests++; if (cap[10] !== 16'd1) begin n_fail++; $display("FAIL ovr_n10: got %0d expected 1", cap[10]); end
    n_tests++; if (cap[5] !== 16'd5) begin n_fail++; $display("FAIL ovr_n5: got %0d expected 5", cap[5]); end
    n_tests++; if (o_tick_ovr !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b expected 1", o_tick_ovr); end
    repeat (5) @(posedge clk);
    #1;
    n_tests++; if (o_tick_ovr !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b expected 1", o_tick_ovr); end
    n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL ovr_no_rescan: got %b expected 0", o_busy); end
  endtask

  task automatic test_reset_mid();
    int fall, efa_cnt, bad;
    @(posedge clk); #1;
    tick = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      tick       = 1'b0;
      spike_in   = (k == 5);   // pending for neuron 200 when reset hits
      spike_addr = 8'd200;
      if (k == 102) begin
        n_tests++; if (o_re !== 1'b1) begin n_fail++; $display("FAIL mid_re_n100: got %b expected 1", o_re); end
        reset = 1'b1;
      end
      if (k == 103) begin
        n_tests++; if (o_re !== 1'b0) begin n_fail++; $display("FAIL mid_re_off: got %b expected 0", o_re); end
        n_tests++; if (o_efa_vld !== 1'b0) begin n_fail++; $display("FAIL mid_efa_off: got %b expected 0", o_efa_vld); end
        n_tests++; if (o_tick_ovr !== 1'b0) begin n_fail++; $display("FAIL mid_ovr_clr: got %b expected 0", o_tick_ovr); end
        reset = 1'b0;
        break;
      end
    end
    fall = -1; efa_cnt = 0;
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk); #1;
      if (o_efa_vld) efa_cnt++;
      if (!o_busy) begin fall = c; break; end
    end
    n_tests++; if (efa_cnt != 0) begin n_fail++; $display("FAIL mid_efa_after: got %0d expected 0", efa_cnt); end
    n_tests++; if (fall != 256) begin n_fail++; $display("FAIL mid_reinit_len: got %0d expected 256", fall); end
    run_scan(0, 8'd0, 0);
    bad = 0;
    for (int i = 0; i < N; i++) if (cap[i] !== 16'hFFFF) bad++;
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL mid_all_max: got %0d non-65535 values expected 0", bad); end
    n_tests++; if (done_k != 262) begin n_fail++; $display("FAIL mid_done_time: got t+%0d expected t+262", done_k); end
  endtask

  initial begin
    test_reset();
    test_all_max();
    test_spike_accum();
    test_spike_race();
    test_tick_ovr();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ts_timer_scan.md
TS_TIMER_SCAN -- requirements
Module: ts_timer_scan

Interface
REQ-001 SHALL have parameter NEURON_NUM, default 256, number of neurons tracked; NEUR_ADDR_LEN = clog2(NEURON_NUM) is derived.
REQ-002 SHALL have parameters SCAL_ADDR_LEN and TEMP_ADDR_LEN, both default 8; T_FIX_WID = SCAL_ADDR_LEN + TEMP_ADDR_LEN.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  system clock.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 tick  in  1  single-cycle pulse that starts one time-step scan.
REQ-007 spike_in  in  1  a neuron fired this cycle.
REQ-008 spike_addr  in  NEUR_ADDR_LEN  index of the firing neuron.
REQ-009 re  out  1  t_fix_reg is valid and drives the exponential stage.
REQ-010 t_fix_reg  out  T_FIX_WID  elapsed time steps since the neuron's last spike.
REQ-011 efa_vld  out  1  exponential-stage output is valid this cycle.
REQ-012 efa_addr  out  NEUR_ADDR_LEN  neuron index aligned with the exponential-stage output.
REQ-013 busy  out  1  high in INIT, SCAN and DRAIN.
REQ-014 done  out  1  one-cycle pulse marking scan completion.
REQ-015 tick_ovr  out  1  sticky flag: a tick arrived while busy.

Function
REQ-016 SHALL hold one T_FIX_WID timestamp per neuron in a RAM with synchronous read and one write port; TS_MAX = 2^T_FIX_WID-1.
REQ-017 SHALL implement states INIT, IDLE, SCAN and DRAIN.
REQ-018 INIT SHALL write TS_MAX to addresses 0..NEURON_NUM-1, one per cycle, and then enter IDLE.
REQ-019 IDLE + tick at cycle t SHALL enter SCAN at t+1.
REQ-020 SCAN SHALL issue read address n at cycle t+1+n for n = 0..NEURON_NUM-1, then enter DRAIN.
REQ-021 For neuron n, re=1 SHALL be asserted at t+2+n, and t_fix_reg SHALL carry the presented value.
REQ-022 Presented value SHALL be 0 if pend[n] was set when read n issued, otherwise the stored value.
REQ-023 In the cycle re is high for n, the block SHALL write back the presented value +1, saturating at TS_MAX.
REQ-024 When re=0, t_fix_reg SHALL be 0.
REQ-025 spike_in in any state except INIT SHALL set pend[spike_addr]; in INIT, spike_in SHALL be ignored.
REQ-026 pend[n] SHALL be cleared when read n issues; a set in the same cycle for the same n SHALL win, so the spike applies at the next step.
REQ-027 efa_vld/efa_addr SHALL be re/neuron index delayed EFA_LAT=4 cycles: efa_vld for n at t+6+n.
REQ-028 DRAIN SHALL last until the last efa_vld; done SHALL pulse at t+6+NEURON_NUM and the FSM SHALL then return to IDLE.
REQ-029 A tick while busy SHALL be ignored and SHALL set tick_ovr, which clears only on reset.

Reset
REQ-030 Reset SHALL force: state INIT, scan counter 0, pend all 0, delay pipeline cleared.
REQ-031 Reset SHALL force outputs: re=0, t_fix_reg=0, efa_vld=0, efa_addr=0, done=0, tick_ovr=0, busy=1.
REQ-032 Reset asserted mid-scan SHALL abort the scan with no further efa_vld, and INIT SHALL rerun.

Structure
REQ-033 Package ts_pkg SHALL hold T_FIX_WID, TS_MAX, EFA_LAT=4 and the state enum type.
REQ-034 The timestamp memory SHALL be a sub-module ts_ram: simple dual-port, distributed RAM, one-cycle registered read.

Verification
REQ-035 Reset, then 256 cycles -> busy falls; tick -> all 256 t_fix_reg = 65535.
REQ-036 spike_addr=5 in IDLE, tick -> neuron 5 presents 0; next tick -> 1; next tick -> 2; others stay 65535.
REQ-037 tick at cycle t -> first re at t+2, efa_vld for n=0 at t+6, last efa_addr=255 at t+261, done at t+262.
REQ-038 spike_addr=10 in the cycle read 10 issues -> neuron 10 presents its old value this step, 0 next step.
REQ-039 tick during SCAN -> ignored, scan unaffected, tick_ovr=1 and held until reset.
REQ-040 reset at neuron 100 of a scan -> re and efa_vld 0 from the next cycle; INIT reruns; next scan presents 65535 for all neurons.
